// File: rtl/monitoreo_multicanal.sv
// Multi-channel temperature monitor: each channel classifies its samples
// against low/high thresholds (with optional hysteresis), counts consecutive
// same-side samples and raises an alert once the count reaches PERSIST.
module monitoreo_multicanal #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned TEMP_W       = 10,
  parameter int unsigned UMBRAL_BAJO  = 180,
  parameter int unsigned UMBRAL_ALTO  = 260,
  parameter int unsigned PERSIST      = 5,
  parameter int unsigned HYST         = 0,
  parameter int unsigned LATCH_ALERTA = 0
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [N_CH*TEMP_W-1:0]   temp_entrada,
  input  logic [N_CH-1:0]          temp_valida,
  input  logic [N_CH-1:0]          alerta_clr,
  output logic [2*N_CH-1:0]        estado_actual,
  output logic [8*N_CH-1:0]        contador_salida,
  output logic [N_CH-1:0]          alerta,
  output logic [N_CH-1:0]          calefactor,
  output logic [N_CH-1:0]          ventilador,
  output logic                     alerta_global,
  output logic [3:0]               canal_alerta
);

  localparam int unsigned CNT_W         = 8;
  localparam int unsigned LIM_BAJO_HYST = UMBRAL_BAJO + HYST;
  // Clamp so a large band cannot underflow the high-side exit threshold.
  localparam int unsigned LIM_ALTO_HYST = (HYST > UMBRAL_ALTO) ? 0 : (UMBRAL_ALTO - HYST);
  localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);
  localparam bit LATCH_ON = (LATCH_ALERTA != 0);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'b00,
    ST_BAJO   = 2'b01,
    ST_ALTO   = 2'b10,
    ST_ALERTA = 2'b11
  } estado_e;

  estado_e          st_q    [N_CH];
  estado_e          st_d    [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]  lado_q, lado_d;
  logic [N_CH-1:0]  alerta_q, alerta_d;
  logic [N_CH-1:0]  calef_q, calef_d;
  logic [N_CH-1:0]  vent_q, vent_d;
  logic             global_q, global_d;
  logic [3:0]       canal_q, canal_d;

  int unsigned      temp_c  [N_CH];
  logic [N_CH-1:0]  lado_bajo_c, lado_alto_c, bajo_c, alto_c;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= ST_NORMAL;
        cnt_q[i] <= '0;
      end
      lado_q   <= '0;
      alerta_q <= '0;
      calef_q  <= '0;
      vent_q   <= '0;
      global_q <= 1'b0;
      canal_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      lado_q   <= lado_d;
      alerta_q <= alerta_d;
      calef_q  <= calef_d;
      vent_q   <= vent_d;
      global_q <= global_d;
      canal_q  <= canal_d;
    end
  end

  // Per-channel sample classification and next state / lado / count.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      lado_d[i] = lado_q[i];

      temp_c[i]      = 32'(temp_entrada[i*TEMP_W +: TEMP_W]);
      lado_bajo_c[i] = (st_q[i] == ST_BAJO) || ((st_q[i] == ST_ALERTA) && !lado_q[i]);
      lado_alto_c[i] = (st_q[i] == ST_ALTO) || ((st_q[i] == ST_ALERTA) && lado_q[i]);
      bajo_c[i]      = (temp_c[i] < UMBRAL_BAJO) ||
                       (lado_bajo_c[i] && (temp_c[i] < LIM_BAJO_HYST));
      alto_c[i]      = !bajo_c[i] &&
                       ((temp_c[i] >= UMBRAL_ALTO) ||
                        (lado_alto_c[i] && (temp_c[i] >= LIM_ALTO_HYST)));

      if (LATCH_ON && alerta_clr[i] && (st_q[i] == ST_ALERTA)) begin
        // Clear wins over a same-cycle sample, which is dropped.
        st_d[i]  = ST_NORMAL;
        cnt_d[i] = '0;
      end else if (temp_valida[i]) begin
        if (!bajo_c[i] && !alto_c[i]) begin
          if (!(LATCH_ON && (st_q[i] == ST_ALERTA))) begin
            st_d[i]  = ST_NORMAL;
            cnt_d[i] = '0;
          end
        end else begin
          if ((st_q[i] != ST_NORMAL) && (lado_q[i] == alto_c[i])) begin
            cnt_d[i] = (cnt_q[i] >= PERSIST_C) ? PERSIST_C : (cnt_q[i] + CNT_W'(1));
          end else begin
            cnt_d[i]  = CNT_W'(1);
            lado_d[i] = alto_c[i];
          end
          if (cnt_d[i] == PERSIST_C) begin
            st_d[i] = ST_ALERTA;
          end else begin
            st_d[i] = lado_d[i] ? ST_ALTO : ST_BAJO;
          end
        end
      end
    end
  end

  // Output decode: per-channel flags from next state, summary from current flags.
  always_comb begin
    alerta_d = '0;
    calef_d  = '0;
    vent_d   = '0;
    canal_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      alerta_d[i] = (st_d[i] == ST_ALERTA);
      calef_d[i]  = (st_d[i] == ST_BAJO) || ((st_d[i] == ST_ALERTA) && !lado_d[i]);
      vent_d[i]   = (st_d[i] == ST_ALTO) || ((st_d[i] == ST_ALERTA) && lado_d[i]);
    end
    global_d = |alerta_q;
    // Scan downward so the lowest alerting channel wins.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (alerta_q[i]) begin
        canal_d = 4'(i);
      end
    end
  end

  // Pack per-channel registers onto the flat output buses.
  always_comb begin
    estado_actual   = '0;
    contador_salida = '0;
    for (int i = 0; i < N_CH; i++) begin
      estado_actual[2*i +: 2]       = st_q[i];
      contador_salida[8*i +: CNT_W] = cnt_q[i];
    end
  end

  assign alerta        = alerta_q;
  assign calefactor    = calef_q;
  assign ventilador    = vent_q;
  assign alerta_global = global_q;
  assign canal_alerta  = canal_q;

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// Directed bench: instance A uses default parameters, instance B uses HYST=4
// with latched alerts. Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point.
module tb_monitoreo_multicanal;

  logic        clk = 1'b0;
  logic        srst;
  logic [39:0] a_temp, b_temp;
  logic [3:0]  a_val, b_val, a_clr, b_clr;
  logic [7:0]  a_est, b_est;
  logic [31:0] a_cnt, b_cnt;
  logic [3:0]  a_alerta, b_alerta, a_cal, b_cal, a_ven, b_ven;
  logic        a_glob, b_glob;
  logic [3:0]  a_canal, b_canal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  monitoreo_multicanal dut_a (
    .clk(clk), .srst(srst), .temp_entrada(a_temp), .temp_valida(a_val),
    .alerta_clr(a_clr), .estado_actual(a_est), .contador_salida(a_cnt),
    .alerta(a_alerta), .calefactor(a_cal), .ventilador(a_ven),
    .alerta_global(a_glob), .canal_alerta(a_canal)
  );

  monitoreo_multicanal #(.HYST(4), .LATCH_ALERTA(1)) dut_b (
    .clk(clk), .srst(srst), .temp_entrada(b_temp), .temp_valida(b_val),
    .alerta_clr(b_clr), .estado_actual(b_est), .contador_salida(b_cnt),
    .alerta(b_alerta), .calefactor(b_cal), .ventilador(b_ven),
    .alerta_global(b_glob), .canal_alerta(b_canal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int ch, input int v);
    a_temp[ch*10 +: 10] = 10'(v);
  endtask

  task automatic set_b(input int ch, input int v);
    b_temp[ch*10 +: 10] = 10'(v);
  endtask

  function automatic logic [1:0] sta(input int ch);
    return a_est[2*ch +: 2];
  endfunction
  function automatic logic [1:0] stb(input int ch);
    return b_est[2*ch +: 2];
  endfunction
  function automatic logic [7:0] cna(input int ch);
    return a_cnt[8*ch +: 8];
  endfunction
  function automatic logic [7:0] cnb(input int ch);
    return b_cnt[8*ch +: 8];
  endfunction

  initial begin
    srst = 1'b1;
    a_temp = '0; b_temp = '0;
    a_val = '0; b_val = '0; a_clr = '0; b_clr = '0;
    tick(); tick();
    chk("rst_est",    32'(a_est), 0);
    chk("rst_cnt",    a_cnt, 0);
    chk("rst_alerta", 32'(a_alerta), 0);
    chk("rst_cal",    32'(a_cal), 0);
    chk("rst_ven",    32'(a_ven), 0);
    chk("rst_glob",   32'(a_glob), 0);
    chk("rst_canal",  32'(a_canal), 0);
    chk("rst_b_est",  32'(b_est), 0);
    srst = 1'b0;

    // Persistent low on ch0
    set_a(0, 150); a_val = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("low_cnt", 32'(cna(0)), 32'(k));
      chk("low_cal", 32'(a_cal[0]), 1);
      if (k < 5) begin
        chk("low_st", 32'(sta(0)), 1);
        chk("low_noalert", 32'(a_alerta[0]), 0);
      end else begin
        chk("low_st_alerta", 32'(sta(0)), 3);
        chk("low_alerta", 32'(a_alerta[0]), 1);
        chk("glob_lag", 32'(a_glob), 0);
      end
    end
    a_val = 4'b0000;
    tick();
    chk("glob_set", 32'(a_glob), 1);
    chk("canal0",   32'(a_canal), 0);
    chk("hold_st0", 32'(sta(0)), 3);

    // Transient high on ch1
    set_a(1, 300); a_val = 4'b0010;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("hi_st",  32'(sta(1)), 2);
      chk("hi_cnt", 32'(cna(1)), 32'(k));
      chk("hi_ven", 32'(a_ven[1]), 1);
      chk("hi_noalert", 32'(a_alerta[1]), 0);
    end
    set_a(1, 220); tick();
    chk("hi_norm_st",  32'(sta(1)), 0);
    chk("hi_norm_cnt", 32'(cna(1)), 0);
    chk("hi_norm_ven", 32'(a_ven[1]), 0);

    // Threshold boundaries and side change on ch2
    a_val = 4'b0100;
    set_a(2, 179); tick(); chk("b179", 32'(sta(2)), 1);
    set_a(2, 180); tick(); chk("b180", 32'(sta(2)), 0); chk("b180_cnt", 32'(cna(2)), 0);
    set_a(2, 259); tick(); chk("b259", 32'(sta(2)), 0);
    set_a(2, 260); tick(); chk("b260", 32'(sta(2)), 2); chk("b260_cnt", 32'(cna(2)), 1);
    tick(); tick(); tick();
    chk("alto4_st", 32'(sta(2)), 2); chk("alto4_cnt", 32'(cna(2)), 4);
    set_a(2, 150); tick();
    chk("flip_st", 32'(sta(2)), 1); chk("flip_cnt", 32'(cna(2)), 1);
    chk("flip_cal", 32'(a_cal[2]), 1); chk("flip_ven", 32'(a_ven[2]), 0);

    // Lowest alerting channel wins
    set_a(0, 220); a_val = 4'b0001; tick();
    chk("ch0_clear", 32'(sta(0)), 0);
    set_a(1, 300); set_a(3, 300); a_val = 4'b1010;
    for (int k = 0; k < 5; k++) tick();
    chk("ch1_alerta", 32'(sta(1)), 3); chk("ch3_alerta", 32'(sta(3)), 3);
    a_val = 4'b0000; tick();
    chk("canal1", 32'(a_canal), 1); chk("glob_13", 32'(a_glob), 1);

    // Reset mid-operation
    set_a(1, 220); a_val = 4'b0010; tick();
    set_a(0, 150); set_a(1, 300);
    for (int k = 0; k < 5; k++) begin
      a_val = (k >= 2) ? 4'b0011 : 4'b0001;
      tick();
    end
    chk("pre_rst_st0",  32'(sta(0)), 3);
    chk("pre_rst_st1",  32'(sta(1)), 2);
    chk("pre_rst_cnt1", 32'(cna(1)), 3);
    srst = 1'b1; tick();
    chk("mid_rst_est",    32'(a_est), 0);
    chk("mid_rst_cnt",    a_cnt, 0);
    chk("mid_rst_alerta", 32'(a_alerta), 0);
    chk("mid_rst_cal",    32'(a_cal), 0);
    chk("mid_rst_ven",    32'(a_ven), 0);
    chk("mid_rst_glob",   32'(a_glob), 0);
    chk("mid_rst_canal",  32'(a_canal), 0);
    srst = 1'b0; a_val = 4'b0001; tick();
    chk("post_rst_st",  32'(sta(0)), 1);
    chk("post_rst_cnt", 32'(cna(0)), 1);
    a_val = 4'b0000;

    // Hysteresis on instance B
    set_b(2, 150); b_val = 4'b0100; tick(); tick();
    chk("hy_pre_cnt", 32'(cnb(2)), 2);
    set_b(2, 182); tick();
    chk("hy182_st", 32'(stb(2)), 1); chk("hy182_cnt", 32'(cnb(2)), 3);
    set_b(2, 184); tick();
    chk("hy184_st", 32'(stb(2)), 0); chk("hy184_cnt", 32'(cnb(2)), 0);
    set_b(1, 300); b_val = 4'b0010; tick();
    set_b(1, 257); tick();
    chk("hy257_st", 32'(stb(1)), 2); chk("hy257_cnt", 32'(cnb(1)), 2);
    set_b(1, 255); tick();
    chk("hy255_st", 32'(stb(1)), 0);

    // Latched alert on instance B ch3
    set_b(3, 300); b_val = 4'b1000;
    for (int k = 0; k < 5; k++) tick();
    chk("lat_st", 32'(stb(3)), 3); chk("lat_ven", 32'(b_ven[3]), 1);
    set_b(3, 220);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lat_hold_st",  32'(stb(3)), 3);
      chk("lat_hold_cnt", 32'(cnb(3)), 5);
      chk("lat_hold_al",  32'(b_alerta[3]), 1);
    end
    set_b(3, 100); b_clr = 4'b1000; tick();
    chk("clr_st",  32'(stb(3)), 0); chk("clr_cnt", 32'(cnb(3)), 0);
    chk("clr_al",  32'(b_alerta[3]), 0); chk("clr_cal", 32'(b_cal[3]), 0);
    b_clr = 4'b0000; tick();
    chk("post_clr_st", 32'(stb(3)), 1);
    b_clr = 4'b1000; tick();
    chk("clr_ign_st",  32'(stb(3)), 1); chk("clr_ign_cnt", 32'(cnb(3)), 2);
    b_clr = 4'b0000; b_val = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
